// File: rtl/block_offset_scheduler_pkg.sv
// Shared types for the block offset scheduler: grid geometry, offset vectors and FSM states.
package block_offset_scheduler_pkg;

    localparam int unsigned DIM = 4;
    localparam int unsigned BW  = 16;

    typedef logic [BW-1:0]    BOfs_t;
    typedef BOfs_t [DIM-1:0]  BVec_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/block_offset_scheduler_if.sv
// Configuration and block-offset handshake bundle for block_offset_scheduler.
interface block_offset_scheduler_if;
    import block_offset_scheduler_pkg::*;

    logic  cfg_rdy;
    logic  cfg_ack;
    BVec_t i_bend;
    BVec_t i_bstride;
    logic  bofs_rdy;
    logic  bofs_ack;
    BVec_t o_bofs;
    logic  o_last;

    modport master (
        output cfg_rdy, i_bend, i_bstride, bofs_ack,
        input  cfg_ack, bofs_rdy, o_bofs, o_last
    );

    modport slave (
        input  cfg_rdy, i_bend, i_bstride, bofs_ack,
        output cfg_ack, bofs_rdy, o_bofs, o_last
    );

endinterface

// File: rtl/block_offset_scheduler_step.sv
// Single-dimension stepper: advances one offset by its stride and carries out on wrap.
module block_offset_step
    import block_offset_scheduler_pkg::*;
(
    input  BOfs_t ofs_i,
    input  BOfs_t stride_i,
    input  BOfs_t bend_i,
    input  logic  carry_i,
    output BOfs_t ofs_nxt_o,
    output logic  carry_o
);

    logic [BW:0] sum;
    logic        wrap;

    always_comb begin
        // One extra bit so ofs+stride near 2^BW cannot alias back below bend.
        sum       = {1'b0, ofs_i} + {1'b0, stride_i};
        wrap      = (stride_i == '0) || (sum >= {1'b0, bend_i});
        ofs_nxt_o = ofs_i;
        carry_o   = 1'b0;
        if (carry_i) begin
            carry_o   = wrap;
            ofs_nxt_o = wrap ? '0 : sum[BW-1:0];
        end
    end

endmodule

// File: rtl/block_offset_scheduler.sv
// Walks an N-D block grid row-major and emits one offset vector per bofs transfer.
// Optional transfer counter o_bcount enabled by BLOCK_OFFSET_SCHEDULER_COUNT_EN.
module block_offset_scheduler
    import block_offset_scheduler_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    block_offset_scheduler_if.slave bus
`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
    ,
    output logic [31:0] o_bcount
`endif
);

    state_e state_q, state_d;
    logic   rdy_q, rdy_d;
    BVec_t  ofs_q, ofs_d;
    BVec_t  bend_q, bend_d;
    BVec_t  stride_q, stride_d;

    logic   carry [DIM+1];
    BOfs_t  ofs_nxt [DIM];
    BVec_t  ofs_step;
    logic   last;
    logic   cfg_empty;
    logic   cfg_ack;

    // Innermost dimension always steps; the carry out of dim 0 means the whole grid wraps.
    assign carry[DIM] = 1'b1;

    for (genvar g = 0; g < DIM; g++) begin : gen_step
        block_offset_step u_step (
            .ofs_i     (ofs_q[g]),
            .stride_i  (stride_q[g]),
            .bend_i    (bend_q[g]),
            .carry_i   (carry[g+1]),
            .ofs_nxt_o (ofs_nxt[g]),
            .carry_o   (carry[g])
        );
    end

    assign last = carry[0];

    always_comb begin
        cfg_empty = 1'b0;
        ofs_step  = '0;
        for (int d = 0; d < DIM; d++) begin
            if (bus.i_bend[d] == '0) cfg_empty = 1'b1;
            ofs_step[d] = ofs_nxt[d];
        end
    end

    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        ofs_d    = ofs_q;
        bend_d   = bend_q;
        stride_d = stride_q;
        cfg_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_rdy) begin
                    cfg_ack  = 1'b1;
                    bend_d   = bus.i_bend;
                    stride_d = bus.i_bstride;
                    ofs_d    = '0;
                    if (!cfg_empty) begin
                        state_d = StRun;
                        rdy_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                if (bus.bofs_ack) begin
                    if (last) begin
                        state_d = StIdle;
                        rdy_d   = 1'b0;
                        ofs_d   = '0;
                    end else begin
                        ofs_d = ofs_step;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= StIdle;
            rdy_q    <= 1'b0;
            ofs_q    <= '0;
            bend_q   <= '0;
            stride_q <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            ofs_q    <= ofs_d;
            bend_q   <= bend_d;
            stride_q <= stride_d;
        end
    end

    assign bus.cfg_ack  = cfg_ack;
    assign bus.bofs_rdy = rdy_q;
    assign bus.o_bofs   = ofs_q;
    // Latched geometry is meaningless while idle, so last is qualified by rdy.
    assign bus.o_last   = rdy_q & last;

`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
    logic [31:0] bcount_q, bcount_d;

    always_comb begin
        bcount_d = bcount_q;
        if (cfg_ack) begin
            bcount_d = '0;
        end else if (rdy_q && bus.bofs_ack && (bcount_q != 32'hFFFF_FFFF)) begin
            bcount_d = bcount_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) bcount_q <= '0;
        else        bcount_q <= bcount_d;
    end

    assign o_bcount = bcount_q;
`endif

endmodule

// File: tb/tb_block_offset_scheduler.sv
// Directed bench for block_offset_scheduler with a row-major reference scoreboard.
module tb_block_offset_scheduler;
    import block_offset_scheduler_pkg::*;

    typedef struct packed {
        BVec_t ofs;
        logic  last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_offset_scheduler_if bus ();

`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
    logic [31:0] bcount;
`endif

    block_offset_scheduler dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .bus      (bus)
`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
        ,
        .o_bcount (bcount)
`endif
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic BVec_t mk(input int a, input int b, input int c, input int d);
        BVec_t v;
        v[0] = BOfs_t'(a);
        v[1] = BOfs_t'(b);
        v[2] = BOfs_t'(c);
        v[3] = BOfs_t'(d);
        return v;
    endfunction

    // Reference: enumerate each dimension's offsets, then nest loops outer-to-inner.
    task automatic push_model(input BVec_t bend, input BVec_t stride);
        int vals[DIM][$];
        int total;
        int idx;
        int v;
        total = 1;
        idx   = 0;
        for (int d = 0; d < DIM; d++) begin
            if (bend[d] == 0) return;
            v = 0;
            while (1) begin
                vals[d].push_back(v);
                if (stride[d] == 0) break;
                v = v + int'(stride[d]);
                if (v >= int'(bend[d])) break;
            end
            total = total * vals[d].size();
        end
        for (int a = 0; a < vals[0].size(); a++)
            for (int b = 0; b < vals[1].size(); b++)
                for (int c = 0; c < vals[2].size(); c++)
                    for (int e = 0; e < vals[3].size(); e++) begin
                        exp_t x;
                        x.ofs  = mk(vals[0][a], vals[1][b], vals[2][c], vals[3][e]);
                        x.last = (idx == total - 1);
                        idx++;
                        exp_q.push_back(x);
                    end
    endtask

    task automatic send_cfg(input BVec_t bend, input BVec_t stride);
        @(negedge clk);
        bus.cfg_rdy   = 1'b1;
        bus.i_bend    = bend;
        bus.i_bstride = stride;
        bus.bofs_ack  = 1'b0;
        #1;
        chk("cfg_ack_idle", bus.cfg_ack, 1);
        chk("idle_no_rdy", bus.bofs_rdy, 0);
        push_model(bend, stride);
    endtask

    task automatic run_walk(input int stall_pct, input bit hold, input int max_xfer,
                            output int cycles);
        int  xfers;
        bit  done;
        xfers  = 0;
        cycles = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus.cfg_rdy  = hold;
            bus.bofs_ack = ($urandom_range(99) >= stall_pct);
            #1;
            if (cycles == 0) chk("first_bofs_latency", bus.bofs_rdy, 1);
            cycles++;
            if (bus.bofs_rdy) begin
                chk("run_no_cfg_ack", bus.cfg_ack, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_bofs", bus.bofs_rdy, 0);
                end else begin
                    chk("o_bofs", bus.o_bofs, exp_q[0].ofs);
                    chk("o_last", bus.o_last, exp_q[0].last);
                    if (bus.bofs_ack) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end else begin
                chk("rdy_dropped", bus.bofs_rdy, 1);
            end
            if (exp_q.size() == 0 || (max_xfer > 0 && xfers == max_xfer)) done = 1'b1;
            if (!done && cycles >= 300) begin
                chk("walk_timeout", exp_q.size(), 0);
                done = 1'b1;
            end
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        bus.bofs_ack = 1'b0;
        #1;
        chk("after_rdy", bus.bofs_rdy, 0);
        chk("after_ofs", bus.o_bofs, 0);
        chk("after_last", bus.o_last, 0);
    endtask

    initial begin
        int cyc;
        bus.cfg_rdy   = 1'b0;
        bus.bofs_ack  = 1'b0;
        bus.i_bend    = '0;
        bus.i_bstride = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", bus.bofs_rdy, 0);
        chk("rst_ofs", bus.o_bofs, 0);
        chk("rst_last", bus.o_last, 0);
        chk("rst_cfg_ack", bus.cfg_ack, 0);
`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
        chk("rst_bcount", bcount, 0);
`endif
        rst_n = 1'b1;

        // Back-to-back walk of a 1x1x2x3 grid.
        send_cfg(mk(1, 1, 2, 3), mk(1, 1, 1, 1));
        run_walk(0, 1'b0, 0, cyc);
        chk("b2b_cycles", cyc, 6);
        check_idle();
`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
        chk("bcount_full", bcount, 6);
`endif

        // Strided walk with random stalls.
        send_cfg(mk(1, 1, 5, 8), mk(1, 1, 2, 4));
        run_walk(40, 1'b0, 0, cyc);
        check_idle();

        // Empty grid, then a config accepted on the very next cycle.
        send_cfg(mk(1, 0, 3, 3), mk(1, 1, 1, 1));
        send_cfg(mk(1, 1, 1, 16'hFFFF), mk(1, 1, 1, 16'h8000));
        run_walk(20, 1'b0, 0, cyc);
        check_idle();

        send_cfg(mk(1, 1, 1, 9), mk(1, 1, 1, 0));
        run_walk(0, 1'b0, 0, cyc);
        check_idle();

        // cfg_rdy held through a 4-block run: single extra ack right after the last transfer.
        send_cfg(mk(1, 1, 2, 2), mk(1, 1, 1, 1));
        @(posedge clk);
        #1;
        bus.i_bend    = mk(1, 2, 1, 2);
        bus.i_bstride = mk(1, 1, 1, 1);
        run_walk(30, 1'b1, 0, cyc);
        check_idle();
        chk("held_cfg_ack", bus.cfg_ack, 1);
        push_model(mk(1, 2, 1, 2), mk(1, 1, 1, 1));
        run_walk(0, 1'b0, 0, cyc);
        check_idle();

        // Reset after the third transfer of a 6-block run.
        send_cfg(mk(1, 1, 2, 3), mk(1, 1, 1, 1));
        run_walk(0, 1'b0, 3, cyc);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.bofs_ack = 1'b0;
        bus.cfg_rdy  = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_rdy", bus.bofs_rdy, 0);
        chk("midrst_ofs", bus.o_bofs, 0);
`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
        chk("midrst_bcount", bcount, 0);
`endif
        rst_n = 1'b1;
        exp_q.delete();

        send_cfg(mk(1, 1, 2, 3), mk(1, 1, 1, 1));
        run_walk(25, 1'b0, 0, cyc);
        check_idle();
`ifdef BLOCK_OFFSET_SCHEDULER_COUNT_EN
        chk("bcount_after_rst_run", bcount, 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
